// File: rtl/seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// seq_det_scheduler
//
// Lets NUM_REQ requesters share one serial sequence detector. A word is picked
// round-robin, the detector is cleared for one cycle, and the word is shifted
// into it MSB-first. The block counts the bit slots in which the detector output
// is high and returns {requester id, hit count} on a valid/ready response.
//
// State sequence: IDLE -> CLEAR -> SHIFT (DATA_W cycles) -> DRAIN -> RESP -> IDLE
//
// Ports
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   req_valid    : per-requester word valid
//   req_data     : flattened words, requester i at [i*DATA_W +: DATA_W]
//   req_ready    : one-hot accept pulse (one cycle, in IDLE only)
//   det_reset_n  : detector clear, low in CLEAR and while reset is high
//   sequence_out : serial bit to the detector's sequence_in
//   detector_in  : detector_out (registered, Moore) from the detector
//   resp_valid   : response valid (RESP state)
//   resp_id      : id of the requester served
//   resp_count   : number of sampled bit slots with detector_in high
//   resp_ready   : response consumer ready
//   busy         : high in every state except IDLE
// -----------------------------------------------------------------------------
module seq_det_scheduler #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 8,
   localparam int CNT_W   = $clog2(DATA_W + 1),
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      det_reset_n,
   output logic                      sequence_out,
   input  logic                      detector_in,
   output logic                      resp_valid,
   output logic [ID_W-1:0]           resp_id,
   output logic [CNT_W-1:0]          resp_count,
   input  logic                      resp_ready,
   output logic                      busy
);

   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SHIFT,
      ST_DRAIN,
      ST_RESP
   } state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   last_grant_reg, last_grant_next;
   logic [ID_W-1:0]   id_reg, id_next;
   logic [DATA_W-1:0] word_reg, word_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;

   // ---------------------------------------------------------------------------
   // Request unpacking and round-robin candidate list.
   // Candidate gi is requester (last_grant + 1 + gi) mod NUM_REQ, so candidate 0
   // has the highest priority. The sum fits in ID_W+1 bits because it never
   // exceeds 2*NUM_REQ-1, so one conditional subtract performs the modulo.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] word_arr   [NUM_REQ];
   logic [ID_W:0]     cand_sum   [NUM_REQ];
   logic [ID_W-1:0]   cand_id    [NUM_REQ];
   logic [NUM_REQ-1:0] cand_valid;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign word_arr[gi]   = req_data[gi*DATA_W +: DATA_W];
      assign cand_sum[gi]   = {1'b0, last_grant_reg} + (ID_W+1)'(gi + 1);
      assign cand_id[gi]    = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                              ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                              : cand_sum[gi][ID_W-1:0];
      assign cand_valid[gi] = req_valid[cand_id[gi]];
   end

   logic            grant_found;
   logic [ID_W-1:0] grant_id;

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && cand_valid[k]) begin
            grant_found = 1'b1;
            grant_id    = cand_id[k];
         end
      end
   end

   // Accept happens only in IDLE; reset suppresses it combinationally so that
   // no requester believes it was served while reset is high.
   logic accept;
   assign accept = (state_reg == ST_IDLE) && grant_found && !reset;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_id == ID_W'(gi));
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
         id_reg         <= '0;
         word_reg       <= '0;
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         id_reg         <= id_next;
         word_reg       <= word_next;
         cnt_reg        <= cnt_next;
         bit_idx_reg    <= bit_idx_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      id_next         = id_reg;
      word_next       = word_reg;
      cnt_next        = cnt_reg;
      bit_idx_next    = bit_idx_reg;

      case (state_reg)
         ST_IDLE: begin
            if (grant_found) begin
               word_next  = word_arr[grant_id];
               id_next    = grant_id;
               state_next = ST_CLEAR;
            end
         end

         ST_CLEAR: begin
            cnt_next     = '0;
            bit_idx_next = IDX_W'(DATA_W - 1);
            state_next   = ST_SHIFT;
         end

         ST_SHIFT: begin
            // The first SHIFT cycle still shows the detector's cleared output,
            // so it is not counted; the last bit's effect is picked up in DRAIN.
            if (bit_idx_reg != IDX_W'(DATA_W - 1)) begin
               cnt_next = cnt_reg + CNT_W'(detector_in);
            end
            if (bit_idx_reg == '0) begin
               state_next = ST_DRAIN;
            end else begin
               bit_idx_next = bit_idx_reg - 1'b1;
            end
         end

         ST_DRAIN: begin
            cnt_next   = cnt_reg + CNT_W'(detector_in);
            state_next = ST_RESP;
         end

         ST_RESP: begin
            if (resp_ready) begin
               last_grant_next = id_reg;
               state_next      = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs. All are forced to their idle/cleared values while reset is high,
   // including det_reset_n, which holds the detector cleared during reset.
   // ---------------------------------------------------------------------------
   assign sequence_out = !reset && (state_reg == ST_SHIFT) && word_reg[bit_idx_reg];
   assign det_reset_n  = !reset && (state_reg != ST_CLEAR);
   assign busy         = !reset && (state_reg != ST_IDLE);
   assign resp_valid   = !reset && (state_reg == ST_RESP);
   assign resp_id      = reset ? '0 : id_reg;
   assign resp_count   = reset ? '0 : cnt_reg;

endmodule
